bp_cfg_loader: RTL

BP_CFG_LOADER -- requirements
Module: bp_cfg_loader

---
 rtl/bp_cfg_loader.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bp_cfg_loader.sv
// bp_cfg_loader
// Boot-time configuration sequencer for a BlackParrot-style tile. It issues one
// uncached 8-byte write at a time over a ready/valid BedRock command channel.
// The sequence is: freeze on, CCE microcode (read from an external
// ROM), CCE mode, icache mode, dcache mode, domain mask, freeze off. Each write
// waits for its response before the next one is issued.
//
// Ports
//   clk_i, reset_i        single clock, synchronous active-high reset
//   cfg_base_addr_i       tile config base, ORed with each register offset
//   mem_cmd_o/_v_o        command message and valid
//   mem_cmd_ready_i       downstream ready
//   mem_resp_i/_v_i       response message and valid
//   mem_resp_yumi_o       response consume strobe
//   ucode_r_v_o           microcode ROM read strobe
//   ucode_addr_o          microcode ROM address (the pc counter)
//   ucode_data_i          ROM data, valid the cycle after the strobe
//   done_o                sequence complete (sticky until reset)
//   err_o                 sticky: some response had a wrong type or address
//
// Message layout, LSB first:
//   msg_type[3:0] | addr[paddr-1:0] | size[2:0] | payload[15:0] | data[dword-1:0]
//
// state        | meaning
// -------------+---------------------------------------------------------
// e_reset      | idle for one cycle after reset, all strobes low
// e_send       | command valid held until accepted
// e_fetch      | ROM read strobe for the current pc
// e_fetch_wait | capture ROM data into the data register
// e_wait_resp  | consume the response, advance the step
// e_done       | sequence finished, all valids low

package bp_cfg_loader_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0,
    e_bp_small_cfg   = 2'd1
  } bp_params_e;

  localparam logic [3:0] e_bedrock_mem_rd    = 4'd0;
  localparam logic [3:0] e_bedrock_mem_wr    = 4'd1;
  localparam logic [3:0] e_bedrock_mem_uc_rd = 4'd2;
  localparam logic [3:0] e_bedrock_mem_uc_wr = 4'd3;

  localparam logic [2:0] e_bedrock_msg_size_8 = 3'b011;

  localparam logic [3:0] e_cce_mode_uncached = 4'd0;
  localparam logic [3:0] e_cce_mode_normal   = 4'd1;
  localparam logic [3:0] e_lce_mode_uncached = 4'd0;
  localparam logic [3:0] e_lce_mode_normal   = 4'd1;
  localparam logic [3:0] e_lce_mode_nonspec  = 4'd2;

  localparam logic [15:0] bp_cfg_reg_freeze_gp      = 16'h0008;
  localparam logic [15:0] bp_cfg_reg_domain_mask_gp = 16'h0024;
  localparam logic [15:0] bp_cfg_reg_icache_mode_gp = 16'h0204;
  localparam logic [15:0] bp_cfg_reg_dcache_mode_gp = 16'h0404;
  localparam logic [15:0] bp_cfg_reg_cce_mode_gp    = 16'h0604;
  localparam logic [15:0] bp_cfg_base_addr_ucode_gp = 16'h8000;

  localparam int mem_payload_width_gp = 16;

endpackage

module bp_cfg_loader
  import bp_cfg_loader_pkg::*;
#(
  parameter bp_params_e bp_params_p   = e_bp_default_cfg,
  parameter int         ucode_words_p = 256,
  parameter bit         skip_ucode_p  = 1'b0,
  parameter logic [3:0] cce_mode_p    = e_cce_mode_normal,
  parameter logic [3:0] lce_mode_p    = e_lce_mode_normal,
  localparam int paddr_width_p        = 40,
  localparam int dword_width_p        = 64,
  localparam int cce_pc_width_p       = (bp_params_p == e_bp_small_cfg) ? 6 : 8,
  localparam int cce_instr_width_p    = 32,
  localparam int xce_mem_msg_width_lp = 4 + paddr_width_p + 3 + mem_payload_width_gp + dword_width_p
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [paddr_width_p-1:0]        cfg_base_addr_i,
  output logic [xce_mem_msg_width_lp-1:0] mem_cmd_o,
  output logic                            mem_cmd_v_o,
  input  logic                            mem_cmd_ready_i,
  input  logic [xce_mem_msg_width_lp-1:0] mem_resp_i,
  input  logic                            mem_resp_v_i,
  output logic                            mem_resp_yumi_o,
  output logic                            ucode_r_v_o,
  output logic [cce_pc_width_p-1:0]       ucode_addr_o,
  input  logic [cce_instr_width_p-1:0]    ucode_data_i,
  output logic                            done_o,
  output logic                            err_o
);

  localparam logic [2:0] e_reset      = 3'd0;
  localparam logic [2:0] e_send       = 3'd1;
  localparam logic [2:0] e_fetch      = 3'd2;
  localparam logic [2:0] e_fetch_wait = 3'd3;
  localparam logic [2:0] e_wait_resp  = 3'd4;
  localparam logic [2:0] e_done       = 3'd5;

  // Sequence steps, in issue order.
  localparam logic [2:0] step_freeze_on  = 3'd0;
  localparam logic [2:0] step_ucode      = 3'd1;
  localparam logic [2:0] step_cce        = 3'd2;
  localparam logic [2:0] step_icache     = 3'd3;
  localparam logic [2:0] step_dcache     = 3'd4;
  localparam logic [2:0] step_domain     = 3'd5;
  localparam logic [2:0] step_freeze_off = 3'd6;

  localparam bit skip_lp = skip_ucode_p || (ucode_words_p == 0);
  // Only meaningful when the ucode phase is present (ucode_words_p >= 1).
  localparam logic [cce_pc_width_p-1:0] last_pc_lp = cce_pc_width_p'(ucode_words_p - 1);

  logic [2:0]                   state_r;
  logic [2:0]                   step_r;
  logic [cce_pc_width_p-1:0]    pc_r;
  logic [cce_instr_width_p-1:0] data_r;
  logic                         err_r;

  logic [15:0]              cmd_offset;
  logic [dword_width_p-1:0] cmd_value;
  logic [paddr_width_p-1:0] cmd_addr;

  // The message is a pure function of registered step/pc/data, so it cannot
  // move while valid is held (cfg_base_addr_i is a static strap).
  always_comb begin
    cmd_offset = 16'h0000;
    cmd_value  = '0;
    case (step_r)
      step_freeze_on: begin
        cmd_offset   = bp_cfg_reg_freeze_gp;
        cmd_value[0] = 1'b1;
      end
      step_ucode: begin
        cmd_offset = bp_cfg_base_addr_ucode_gp | 16'(pc_r);
        cmd_value[cce_instr_width_p-1:0] = data_r;
      end
      step_cce: begin
        cmd_offset     = bp_cfg_reg_cce_mode_gp;
        cmd_value[3:0] = cce_mode_p;
      end
      step_icache: begin
        cmd_offset     = bp_cfg_reg_icache_mode_gp;
        cmd_value[3:0] = lce_mode_p;
      end
      step_dcache: begin
        cmd_offset     = bp_cfg_reg_dcache_mode_gp;
        cmd_value[3:0] = lce_mode_p;
      end
      step_domain: begin
        cmd_offset     = bp_cfg_reg_domain_mask_gp;
        cmd_value[7:0] = 8'h01;
      end
      step_freeze_off: begin
        cmd_offset = bp_cfg_reg_freeze_gp;
      end
      default: begin
        cmd_offset = 16'h0000;
        cmd_value  = '0;
      end
    endcase
  end

  assign cmd_addr  = cfg_base_addr_i | {{(paddr_width_p-16){1'b0}}, cmd_offset};
  assign mem_cmd_o = {cmd_value, {mem_payload_width_gp{1'b0}}, e_bedrock_msg_size_8,
                      cmd_addr, e_bedrock_mem_uc_wr};

  logic [3:0]               resp_type;
  logic [paddr_width_p-1:0] resp_addr;
  logic                     resp_bad;
  logic                     unused_resp;

  assign resp_type   = mem_resp_i[3:0];
  assign resp_addr   = mem_resp_i[paddr_width_p+3:4];
  assign unused_resp = ^mem_resp_i[xce_mem_msg_width_lp-1:paddr_width_p+4];
  // Checked against the address still being driven for the current step.
  assign resp_bad    = (resp_type != e_bedrock_mem_uc_wr) || (resp_addr != cmd_addr);

  assign mem_cmd_v_o     = (state_r == e_send);
  assign mem_resp_yumi_o = (state_r == e_wait_resp) && mem_resp_v_i;
  assign ucode_r_v_o     = (state_r == e_fetch);
  assign ucode_addr_o    = pc_r;
  assign done_o          = (state_r == e_done);
  assign err_o           = err_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_reset;
      step_r  <= step_freeze_on;
      pc_r    <= '0;
      data_r  <= '0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        e_reset: state_r <= e_send;
        e_send: begin
          if (mem_cmd_ready_i) state_r <= e_wait_resp;
        end
        e_fetch: state_r <= e_fetch_wait;
        e_fetch_wait: begin
          data_r  <= ucode_data_i;
          state_r <= e_send;
        end
        e_wait_resp: begin
          if (mem_resp_v_i) begin
            if (resp_bad) err_r <= 1'b1;
            case (step_r)
              step_freeze_on: begin
                if (skip_lp) begin
                  step_r  <= step_cce;
                  state_r <= e_send;
                end else begin
                  step_r  <= step_ucode;
                  pc_r    <= '0;
                  state_r <= e_fetch;
                end
              end
              step_ucode: begin
                // pc parks on the last word rather than wrapping.
                if (pc_r == last_pc_lp) begin
                  step_r  <= step_cce;
                  state_r <= e_send;
                end else begin
                  pc_r    <= pc_r + 1'b1;
                  state_r <= e_fetch;
                end
              end
              step_freeze_off: state_r <= e_done;
              default: begin
                step_r  <= step_r + 3'd1;
                state_r <= e_send;
              end
            endcase
          end
        end
        e_done: state_r <= e_done;
        default: state_r <= e_reset;
      endcase
    end
  end

endmodule
